// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between execute and writeback.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting ops; non-memory ops retire on the next edge
// REQ   | memory request presented, waiting for mem_gnt
// RESP  | load granted, waiting for mem_rvalid
//
// Memory ops are captured into a small set of latches on acceptance so the
// request fields stay stable while upstream is stalled.  All MA outputs are
// registers and all memory-side outputs are decodes of state and latches,
// so no input reaches an output combinationally.
module mem_access_stage #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                REG_IDX_W = 5,
    parameter int                CTRL_W    = 4,
    parameter logic [CTRL_W-1:0] LOAD_OP   = 4'b1100,
    parameter logic [CTRL_W-1:0] STORE_OP  = 4'b1110
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ex_valid,
    input  logic [CTRL_W-1:0]    control_ex,
    input  logic [DATA_W-1:0]    result_ex,
    input  logic [DATA_W-1:0]    reg_data_ex,
    input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
    input  logic                 dest_reg_write_en_ex,
    output logic                 stall_ma,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [DATA_W-1:0]    mem_rdata,

    output logic                 ma_valid,
    output logic [CTRL_W-1:0]    control_ma,
    output logic [DATA_W-1:0]    result_ma,
    output logic [DATA_W-1:0]    data_ma,
    output logic [REG_IDX_W-1:0] dest_reg_index_ma,
    output logic                 dest_reg_write_en_ma
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;

    logic [CTRL_W-1:0]      lat_ctrl_q,  lat_ctrl_d;
    logic [DATA_W-1:0]      lat_res_q,   lat_res_d;
    logic [DATA_W-1:0]      lat_wdata_q, lat_wdata_d;
    logic [REG_IDX_W-1:0]   lat_dest_q,  lat_dest_d;
    logic                   lat_dwe_q,   lat_dwe_d;

    logic                   ma_valid_q,  ma_valid_d;
    logic [CTRL_W-1:0]      ctrl_ma_q,   ctrl_ma_d;
    logic [DATA_W-1:0]      res_ma_q,    res_ma_d;
    logic [DATA_W-1:0]      data_ma_q,   data_ma_d;
    logic [REG_IDX_W-1:0]   dest_ma_q,   dest_ma_d;
    logic                   dwe_ma_q,    dwe_ma_d;

    logic                   ex_is_mem;
    logic                   lat_is_store;

    assign ex_is_mem    = (control_ex == LOAD_OP) || (control_ex == STORE_OP);
    assign lat_is_store = (lat_ctrl_q == STORE_OP);

    // State, latches and MA result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_ctrl_q  <= '0;
            lat_res_q   <= '0;
            lat_wdata_q <= '0;
            lat_dest_q  <= '0;
            lat_dwe_q   <= 1'b0;
            ma_valid_q  <= 1'b0;
            ctrl_ma_q   <= '0;
            res_ma_q    <= '0;
            data_ma_q   <= '0;
            dest_ma_q   <= '0;
            dwe_ma_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_ctrl_q  <= lat_ctrl_d;
            lat_res_q   <= lat_res_d;
            lat_wdata_q <= lat_wdata_d;
            lat_dest_q  <= lat_dest_d;
            lat_dwe_q   <= lat_dwe_d;
            ma_valid_q  <= ma_valid_d;
            ctrl_ma_q   <= ctrl_ma_d;
            res_ma_q    <= res_ma_d;
            data_ma_q   <= data_ma_d;
            dest_ma_q   <= dest_ma_d;
            dwe_ma_q    <= dwe_ma_d;
        end
    end

    // Next state, latch capture and retire logic
    always_comb begin
        state_d     = state_q;
        lat_ctrl_d  = lat_ctrl_q;
        lat_res_d   = lat_res_q;
        lat_wdata_d = lat_wdata_q;
        lat_dest_d  = lat_dest_q;
        lat_dwe_d   = lat_dwe_q;
        // valid and write enable default to a bubble; payload fields hold
        ma_valid_d  = 1'b0;
        dwe_ma_d    = 1'b0;
        ctrl_ma_d   = ctrl_ma_q;
        res_ma_d    = res_ma_q;
        data_ma_d   = data_ma_q;
        dest_ma_d   = dest_ma_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_is_mem) begin
                        lat_ctrl_d  = control_ex;
                        lat_res_d   = result_ex;
                        lat_wdata_d = reg_data_ex;
                        lat_dest_d  = dest_reg_index_ex;
                        lat_dwe_d   = dest_reg_write_en_ex;
                        state_d     = ST_REQ;
                    end else begin
                        ma_valid_d  = 1'b1;
                        ctrl_ma_d   = control_ex;
                        res_ma_d    = result_ex;
                        data_ma_d   = '0;
                        dest_ma_d   = dest_reg_index_ex;
                        dwe_ma_d    = dest_reg_write_en_ex;
                    end
                end
            end
            ST_REQ: begin
                // rvalid arriving with gnt is not a response to this request
                if (mem_gnt) begin
                    if (lat_is_store) begin
                        ma_valid_d = 1'b1;
                        ctrl_ma_d  = lat_ctrl_q;
                        res_ma_d   = lat_res_q;
                        data_ma_d  = '0;
                        dest_ma_d  = lat_dest_q;
                        dwe_ma_d   = lat_dwe_q;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    ma_valid_d = 1'b1;
                    ctrl_ma_d  = lat_ctrl_q;
                    res_ma_d   = lat_res_q;
                    data_ma_d  = mem_rdata;
                    dest_ma_d  = lat_dest_q;
                    dwe_ma_d   = lat_dwe_q;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stall_ma  = (state_q != ST_IDLE);
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = (state_q == ST_REQ) && lat_is_store;
    assign mem_addr  = lat_res_q[ADDR_W-1:0];
    assign mem_wdata = lat_is_store ? lat_wdata_q : '0;

    assign ma_valid             = ma_valid_q;
    assign control_ma           = ctrl_ma_q;
    assign result_ma            = res_ma_q;
    assign data_ma              = data_ma_q;
    assign dest_reg_index_ma    = dest_ma_q;
    assign dest_reg_write_en_ma = dwe_ma_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a
// randomized mix of ALU, load and store ops against a transaction model.
module tb_mem_access_stage;

    localparam logic [3:0] LOAD_OP  = 4'b1100;
    localparam logic [3:0] STORE_OP = 4'b1110;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [3:0]  control_ex;
    logic [15:0] result_ex;
    logic [15:0] reg_data_ex;
    logic [4:0]  dest_reg_index_ex;
    logic        dest_reg_write_en_ex;
    logic        stall_ma;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        ma_valid;
    logic [3:0]  control_ma;
    logic [15:0] result_ma;
    logic [15:0] data_ma;
    logic [4:0]  dest_reg_index_ma;
    logic        dest_reg_write_en_ma;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .ex_valid             (ex_valid),
        .control_ex           (control_ex),
        .result_ex            (result_ex),
        .reg_data_ex          (reg_data_ex),
        .dest_reg_index_ex    (dest_reg_index_ex),
        .dest_reg_write_en_ex (dest_reg_write_en_ex),
        .stall_ma             (stall_ma),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_gnt              (mem_gnt),
        .mem_rvalid           (mem_rvalid),
        .mem_rdata            (mem_rdata),
        .ma_valid             (ma_valid),
        .control_ma           (control_ma),
        .result_ma            (result_ma),
        .data_ma              (data_ma),
        .dest_reg_index_ma    (dest_reg_index_ma),
        .dest_reg_write_en_ma (dest_reg_write_en_ma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_alu_ctrl();
        logic [3:0] c;
        c = 4'($urandom);
        while (c == LOAD_OP || c == STORE_OP) c = 4'($urandom);
        return c;
    endfunction

    task automatic test_reset();
        n_checks++; if (ma_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ma_valid: got %b want 0", ma_valid); end
        n_checks++; if (stall_ma !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_ma); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (result_ma !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_ma); end
        n_checks++; if (data_ma !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_ma); end
        n_checks++; if (dest_reg_write_en_ma !== 1'b0) begin n_fail++; $display("FAIL reset_dwe: got %b want 0", dest_reg_write_en_ma); end
        n_checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0 0", mem_addr, mem_wdata); end
    endtask

    // One ALU op, checked on the following edge
    task automatic alu_op(input logic [3:0] c, input logic [15:0] r, input logic [4:0] d, input logic w);
        ex_valid = 1'b1; control_ex = c; result_ex = r; reg_data_ex = 16'($urandom);
        dest_reg_index_ex = d; dest_reg_write_en_ex = w;
        tick();
        n_checks++; if (ma_valid !== 1'b1) begin n_fail++; $display("FAIL alu_ma_valid: got %b want 1", ma_valid); end
        n_checks++; if (stall_ma !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall_req: got stall %b req %b want 0 0", stall_ma, mem_req); end
        n_checks++; if (control_ma !== c || result_ma !== r || dest_reg_index_ma !== d || dest_reg_write_en_ma !== w)
            begin n_fail++; $display("FAIL alu_fields: got c%h r%h d%0d w%b want c%h r%h d%0d w%b", control_ma, result_ma, dest_reg_index_ma, dest_reg_write_en_ma, c, r, d, w); end
        n_checks++; if (data_ma !== 16'h0) begin n_fail++; $display("FAIL alu_data_ma: got %h want 0", data_ma); end
    endtask

    // Full memory transaction: gd cycles without gnt, rd cycles without
    // rvalid after the grant; noise injects ignored handshakes and junk ops.
    task automatic run_mem_op(input logic is_st, input logic [15:0] addr, input logic [15:0] wd,
                              input logic [4:0] dst, input logic dwe, input int gd, input int rd,
                              input logic [15:0] rdat, input logic noise);
        logic [3:0]  op;
        logic [15:0] exp_wd;
        logic [15:0] exp_data;
        op       = is_st ? STORE_OP : LOAD_OP;
        exp_wd   = is_st ? wd : 16'h0;
        exp_data = is_st ? 16'h0 : rdat;
        ex_valid = 1'b1; control_ex = op; result_ex = addr; reg_data_ex = wd;
        dest_reg_index_ex = dst; dest_reg_write_en_ex = dwe; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
        n_checks++; if (ma_valid !== 1'b0 || dest_reg_write_en_ma !== 1'b0) begin n_fail++; $display("FAIL mem_accept_no_retire: got v%b w%b want 0 0", ma_valid, dest_reg_write_en_ma); end
        // junk presented while stalled must be ignored
        control_ex = noise ? 4'h3 : LOAD_OP; result_ex = 16'($urandom); reg_data_ex = 16'($urandom);
        for (int i = 0; i <= gd; i++) begin
            n_checks++; if (stall_ma !== 1'b1 || mem_req !== 1'b1 || ma_valid !== 1'b0)
                begin n_fail++; $display("FAIL req_phase: got stall %b req %b v %b want 1 1 0", stall_ma, mem_req, ma_valid); end
            n_checks++; if (mem_we !== is_st || mem_addr !== addr || mem_wdata !== exp_wd)
                begin n_fail++; $display("FAIL req_bus: got we%b a%h wd%h want we%b a%h wd%h", mem_we, mem_addr, mem_wdata, is_st, addr, exp_wd); end
            mem_gnt    = (i == gd);
            mem_rvalid = noise && (i == gd);
            mem_rdata  = 16'($urandom);
            tick();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!is_st) begin
            for (int i = 0; i <= rd; i++) begin
                n_checks++; if (stall_ma !== 1'b1 || mem_req !== 1'b0 || ma_valid !== 1'b0)
                    begin n_fail++; $display("FAIL resp_phase: got stall %b req %b v %b want 1 0 0", stall_ma, mem_req, ma_valid); end
                mem_rvalid = (i == rd);
                mem_rdata  = (i == rd) ? rdat : 16'($urandom);
                mem_gnt    = noise ? 1'($urandom_range(1)) : 1'b0;
                tick();
            end
        end
        ex_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        n_checks++; if (ma_valid !== 1'b1 || stall_ma !== 1'b0 || mem_req !== 1'b0)
            begin n_fail++; $display("FAIL mem_retire: got v%b stall%b req%b want 1 0 0", ma_valid, stall_ma, mem_req); end
        n_checks++; if (control_ma !== op || result_ma !== addr || data_ma !== exp_data)
            begin n_fail++; $display("FAIL mem_retire_fields: got c%h r%h d%h want c%h r%h d%h", control_ma, result_ma, data_ma, op, addr, exp_data); end
        n_checks++; if (dest_reg_index_ma !== dst || dest_reg_write_en_ma !== dwe)
            begin n_fail++; $display("FAIL mem_retire_dest: got %0d/%b want %0d/%b", dest_reg_index_ma, dest_reg_write_en_ma, dst, dwe); end
    endtask

    task automatic test_alu_stream();
        for (int i = 1; i <= 3; i++) alu_op(4'h1, 16'(i), 5'd5, 1'b1);
        ex_valid = 1'b0;
    endtask

    task automatic test_bubble();
        alu_op(4'h2, 16'h0777, 5'd9, 1'b1);
        ex_valid = 1'b0;
        tick();
        n_checks++; if (ma_valid !== 1'b0 || dest_reg_write_en_ma !== 1'b0)
            begin n_fail++; $display("FAIL bubble_valid_we: got v%b w%b want 0 0", ma_valid, dest_reg_write_en_ma); end
        n_checks++; if (result_ma !== 16'h0777 || dest_reg_index_ma !== 5'd9 || control_ma !== 4'h2)
            begin n_fail++; $display("FAIL bubble_hold: got r%h d%0d c%h want r0777 d9 c2", result_ma, dest_reg_index_ma, control_ma); end
    endtask

    task automatic test_store();
        run_mem_op(1'b1, 16'h0040, 16'h1234, 5'd3, 1'b0, 2, 0, 16'h0, 1'b0);
    endtask

    task automatic test_load();
        run_mem_op(1'b0, 16'h0010, 16'h5555, 5'd7, 1'b1, 0, 3, 16'hA5A5, 1'b0);
    endtask

    task automatic test_spurious();
        logic [15:0] held;
        held = data_ma;
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
            tick();
            n_checks++; if (stall_ma !== 1'b0 || mem_req !== 1'b0 || ma_valid !== 1'b0 || data_ma !== held)
                begin n_fail++; $display("FAIL idle_spurious: got stall%b req%b v%b d%h want 0 0 0 %h", stall_ma, mem_req, ma_valid, data_ma, held); end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        // rvalid alongside gnt must not complete the load
        run_mem_op(1'b0, 16'h0222, 16'h0, 5'd1, 1'b1, 1, 2, 16'h3C3C, 1'b1);
        run_mem_op(1'b0, 16'h0333, 16'h0, 5'd2, 1'b1, 0, 0, 16'h4D4D, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_mem_op(1'b1, 16'h1000, 16'hCAFE, 5'd4, 1'b0, 0, 0, 16'h0, 1'b0);
        run_mem_op(1'b0, 16'h1002, 16'h0, 5'd6, 1'b1, 0, 0, 16'h9876, 1'b0);
        alu_op(4'h5, 16'h00AA, 5'd8, 1'b1);
        ex_valid = 1'b0;
    endtask

    task automatic test_random();
        int kind;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(3));
            if (kind <= 1)
                alu_op(rand_alu_ctrl(), 16'($urandom), 5'($urandom), 1'($urandom));
            else
                run_mem_op(kind == 3, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom),
                           int'($urandom_range(4)), int'($urandom_range(4)), 16'($urandom), 1'($urandom));
            if ($urandom_range(3) == 0) begin
                ex_valid = 1'b0;
                tick();
                n_checks++; if (ma_valid !== 1'b0 || dest_reg_write_en_ma !== 1'b0)
                    begin n_fail++; $display("FAIL rand_bubble: got v%b w%b want 0 0", ma_valid, dest_reg_write_en_ma); end
            end
        end
        ex_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        ex_valid = 1'b1; control_ex = LOAD_OP; result_ex = 16'h0050; reg_data_ex = 16'h0;
        dest_reg_index_ex = 5'd10; dest_reg_write_en_ex = 1'b1;
        tick();
        ex_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        n_checks++; if (stall_ma !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rml_in_resp: got stall%b req%b want 1 0", stall_ma, mem_req); end
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || stall_ma !== 1'b0 || ma_valid !== 1'b0)
            begin n_fail++; $display("FAIL rml_async: got req%b stall%b v%b want 0 0 0", mem_req, stall_ma, ma_valid); end
        n_checks++; if (data_ma !== 16'h0 || result_ma !== 16'h0) begin n_fail++; $display("FAIL rml_clear: got d%h r%h want 0 0", data_ma, result_ma); end
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_rvalid = 1'b0;
        tick();
        n_checks++; if (data_ma !== 16'h0 || ma_valid !== 1'b0 || stall_ma !== 1'b0)
            begin n_fail++; $display("FAIL rml_late_rvalid: got d%h v%b stall%b want 0 0 0", data_ma, ma_valid, stall_ma); end
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; control_ex = '0; result_ex = '0; reg_data_ex = '0;
        dest_reg_index_ex = '0; dest_reg_write_en_ex = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        test_reset();
        tick();
        tick();
        reset = 1'b0;
        test_alu_stream();
        test_bubble();
        test_store();
        test_load();
        test_spurious();
        test_back_to_back();
        test_random();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
